// File: rtl/shot_timer_arbiter_if.sv
// ---------------------------------------------------------------------------
// shot_timer_arbiter_if
// Bundles the requester-side valid/ready bus and the timer-side fire/done bus
// of the shot timer arbiter.
//   req_valid/req_mode  : per-requester shot request and 2-bit duration code
//   req_ready/req_done  : one-hot accept and one-cycle completion pulse
//   tmr_fire_valid/mode : fire request toward the pulse timer
//   tmr_fire_ready/done : timer accept and completion pulse
// Modports:
//   master : the arbiter (drives ready/done and the timer fire request)
//   slave  : the environment (requesters plus the timer)
// ---------------------------------------------------------------------------
interface shot_timer_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [2*NUM_REQ-1:0] req_mode;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   req_done;
    logic                 tmr_fire_valid;
    logic [1:0]           tmr_mode;
    logic                 tmr_fire_ready;
    logic                 tmr_done;

    modport master (
        input  req_valid,
        input  req_mode,
        output req_ready,
        output req_done,
        output tmr_fire_valid,
        output tmr_mode,
        input  tmr_fire_ready,
        input  tmr_done
    );

    modport slave (
        output req_valid,
        output req_mode,
        input  req_ready,
        input  req_done,
        input  tmr_fire_valid,
        input  tmr_mode,
        output tmr_fire_ready,
        output tmr_done
    );
endinterface

// File: rtl/shot_timer_arbiter.sv
// ---------------------------------------------------------------------------
// shot_timer_arbiter
// Round-robin arbiter sharing one single-shot pulse timer among NUM_REQ
// requesters. One shot is in flight at a time: IDLE grants a requester,
// FIRE presents the shot to the timer, RUN waits for the timer's done pulse
// and then returns a one-cycle completion pulse to the owner. A watchdog
// recovers from a lost done and sets a sticky error flag.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   bus          : requester and timer handshakes (master modport)
//   owner        : index of the current owner, valid with owner_valid
//   owner_valid  : high while a shot is in FIRE or RUN
//   timeout_err  : sticky watchdog flag, cleared only by reset
// ---------------------------------------------------------------------------
module shot_timer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDXW    = $clog2(NUM_REQ),
    parameter int TIMEOUT = 300,
    parameter int WDW     = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shot_timer_arbiter_if.master bus,
    output logic [IDXW-1:0]      owner,
    output logic                 owner_valid,
    output logic                 timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FIRE = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t               state_r, state_s;
    logic [IDXW-1:0]      rr_r, rr_s;
    logic [IDXW-1:0]      owner_r, owner_s;
    logic [1:0]           mode_r, mode_s;
    logic                 fire_r, fire_s;
    logic                 err_r, err_s;
    logic [WDW-1:0]       wd_r, wd_s;
    logic [NUM_REQ-1:0]   done_r, done_s;

    logic                 grant_found_s;
    logic [IDXW-1:0]      grant_idx_s;
    logic [NUM_REQ-1:0]   grant_oh_s;
    logic [NUM_REQ-1:0]   owner_oh_s;
    logic                 trip_s;

    // Round-robin search: first valid request at or after the rr pointer.
    always_comb begin
        int idx_v;
        idx_v         = 0;
        grant_found_s = 1'b0;
        grant_idx_s   = {IDXW{1'b0}};
        grant_oh_s    = {NUM_REQ{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_v = int'(rr_r) + k;
            if (idx_v >= NUM_REQ) begin
                idx_v = idx_v - NUM_REQ;
            end else begin
                idx_v = idx_v;
            end
            if (!grant_found_s && bus.req_valid[idx_v]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = idx_v[IDXW-1:0];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        if (grant_found_s) begin
            grant_oh_s[grant_idx_s] = 1'b1;
        end else begin
            grant_oh_s = {NUM_REQ{1'b0}};
        end
    end

    // One-hot decode of the owner, used to route the completion pulse.
    always_comb begin
        owner_oh_s          = {NUM_REQ{1'b0}};
        owner_oh_s[owner_r] = 1'b1;
    end

    // Watchdog reaches TIMEOUT on the cycle it holds TIMEOUT-1.
    assign trip_s = (wd_r == WDW'(TIMEOUT - 1));

    // Grant is offered only in IDLE and never while reset is asserted.
    assign bus.req_ready = (rst_n && (state_r == ST_IDLE)) ? grant_oh_s : {NUM_REQ{1'b0}};

    // Next-state and next-output logic for the IDLE/FIRE/RUN controller.
    always_comb begin
        state_s = state_r;
        rr_s    = rr_r;
        owner_s = owner_r;
        mode_s  = mode_r;
        fire_s  = fire_r;
        err_s   = err_r;
        wd_s    = wd_r;
        done_s  = {NUM_REQ{1'b0}};
        case (state_r)
            ST_IDLE: begin
                wd_s = {WDW{1'b0}};
                if (grant_found_s) begin
                    state_s = ST_FIRE;
                    owner_s = grant_idx_s;
                    mode_s  = bus.req_mode[2*int'(grant_idx_s) +: 2];
                    fire_s  = 1'b1;
                    if (grant_idx_s == IDXW'(NUM_REQ - 1)) begin
                        rr_s = {IDXW{1'b0}};
                    end else begin
                        rr_s = grant_idx_s + IDXW'(1);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_FIRE: begin
                // A done pulse here belongs to an earlier shot and is ignored.
                if (fire_r && bus.tmr_fire_ready) begin
                    state_s = ST_RUN;
                    fire_s  = 1'b0;
                    wd_s    = {WDW{1'b0}};
                end else if (trip_s) begin
                    state_s = ST_IDLE;
                    fire_s  = 1'b0;
                    err_s   = 1'b1;
                    done_s  = owner_oh_s;
                    wd_s    = {WDW{1'b0}};
                end else begin
                    wd_s = wd_r + WDW'(1);
                end
            end
            ST_RUN: begin
                // A done coinciding with the trip is a normal completion.
                if (bus.tmr_done) begin
                    state_s = ST_IDLE;
                    done_s  = owner_oh_s;
                    wd_s    = {WDW{1'b0}};
                end else if (trip_s) begin
                    state_s = ST_IDLE;
                    err_s   = 1'b1;
                    done_s  = owner_oh_s;
                    wd_s    = {WDW{1'b0}};
                end else begin
                    wd_s = wd_r + WDW'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                fire_s  = 1'b0;
                wd_s    = {WDW{1'b0}};
            end
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            rr_r    <= {IDXW{1'b0}};
            owner_r <= {IDXW{1'b0}};
            mode_r  <= 2'b00;
            fire_r  <= 1'b0;
            err_r   <= 1'b0;
            wd_r    <= {WDW{1'b0}};
            done_r  <= {NUM_REQ{1'b0}};
        end else begin
            state_r <= state_s;
            rr_r    <= rr_s;
            owner_r <= owner_s;
            mode_r  <= mode_s;
            fire_r  <= fire_s;
            err_r   <= err_s;
            wd_r    <= wd_s;
            done_r  <= done_s;
        end
    end

    assign bus.tmr_fire_valid = fire_r;
    assign bus.tmr_mode       = mode_r;
    assign bus.req_done       = done_r;
    assign owner              = owner_r;
    assign owner_valid        = (state_r != ST_IDLE);
    assign timeout_err        = err_r;

endmodule

// File: tb/tb_shot_timer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_shot_timer_arbiter
// Directed self-checking bench for shot_timer_arbiter (NUM_REQ=4,
// TIMEOUT=300). Each task drives one scenario and checks the DUT against
// hand-computed values. Inputs change and outputs are sampled 1 time unit
// after the rising clock edge.
// ---------------------------------------------------------------------------
module tb_shot_timer_arbiter;

    logic       clk;
    logic       rst_n;
    logic [1:0] owner;
    logic       owner_valid;
    logic       timeout_err;
    int         errs;
    int         checks;

    shot_timer_arbiter_if #(.NUM_REQ(4)) bus();

    shot_timer_arbiter #(
        .NUM_REQ(4),
        .IDXW(2),
        .TIMEOUT(300),
        .WDW(10)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .owner(owner),
        .owner_valid(owner_valid),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n              = 1'b0;
        bus.req_valid      = 4'b0000;
        bus.req_mode       = 8'h00;
        bus.tmr_fire_ready = 1'b1;
        bus.tmr_done       = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        #2;
        checks++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL reset_ready got=%b exp=0000", bus.req_ready); end
        checks++; if (bus.tmr_fire_valid !== 1'b0 || bus.tmr_mode !== 2'b00) begin errs++; $display("FAIL reset_fire got=%b/%b exp=0/00", bus.tmr_fire_valid, bus.tmr_mode); end
        checks++; if (bus.req_done !== 4'b0000 || owner !== 2'd0 || owner_valid !== 1'b0 || timeout_err !== 1'b0) begin
            errs++; $display("FAIL reset_outputs done=%b owner=%0d ov=%b err=%b exp 0000/0/0/0", bus.req_done, owner, owner_valid, timeout_err);
        end
        apply_reset();
    endtask

    task automatic test_single();
        int bad;
        apply_reset();
        bus.req_mode  = 8'b0000_0010;
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL single_ready got=%b exp=0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.tmr_fire_valid !== 1'b1 || bus.tmr_mode !== 2'b10) begin errs++; $display("FAIL single_fire got=%b/%b exp=1/10", bus.tmr_fire_valid, bus.tmr_mode); end
        checks++; if (owner_valid !== 1'b1 || owner !== 2'd0 || bus.req_ready !== 4'b0000) begin errs++; $display("FAIL single_owner ov=%b owner=%0d ready=%b exp 1/0/0000", owner_valid, owner, bus.req_ready); end
        tick();
        checks++; if (bus.tmr_fire_valid !== 1'b0 || owner_valid !== 1'b1) begin errs++; $display("FAIL single_run fire=%b ov=%b exp 0/1", bus.tmr_fire_valid, owner_valid); end
        bad = 0;
        for (int i = 1; i < 130; i++) begin
            tick();
            if (bus.req_done !== 4'b0000 || owner !== 2'd0 || owner_valid !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errs++; $display("FAIL single_wait bad_cycles got=%0d exp=0", bad); end
        bus.tmr_done = 1'b1;
        tick();
        bus.tmr_done = 1'b0;
        checks++; if (bus.req_done !== 4'b0001 || owner_valid !== 1'b0) begin errs++; $display("FAIL single_done done=%b ov=%b exp 0001/0", bus.req_done, owner_valid); end
        tick();
        checks++; if (bus.req_done !== 4'b0000) begin errs++; $display("FAIL single_done_once got=%b exp=0000", bus.req_done); end
    endtask

    task automatic test_fairness();
        int cnt;
        int exp;
        int dones;
        logic [3:0] exp_oh;
        apply_reset();
        bus.req_mode  = 8'hE4;
        bus.req_valid = 4'b1111;
        dones = 0;
        #1;
        for (int s = 0; s < 6; s++) begin
            exp = s % 4;
            exp_oh = 4'b0001 << exp;
            cnt = 0;
            while (bus.req_ready == 4'b0000 && cnt < 20) begin tick(); cnt++; end
            checks++; if (bus.req_ready !== exp_oh) begin errs++; $display("FAIL fair_grant%0d got=%b exp=%b", s, bus.req_ready, exp_oh); end
            tick();
            checks++; if (owner !== exp[1:0] || bus.tmr_mode !== exp[1:0] || bus.tmr_fire_valid !== 1'b1) begin
                errs++; $display("FAIL fair_fire%0d owner=%0d mode=%0d fv=%b exp %0d/%0d/1", s, owner, bus.tmr_mode, bus.tmr_fire_valid, exp, exp);
            end
            tick();
            for (int c = 0; c < 4; c++) begin
                checks++; if (bus.req_done !== 4'b0000 || bus.req_ready !== 4'b0000) begin errs++; $display("FAIL fair_run%0d done=%b ready=%b exp 0000/0000", s, bus.req_done, bus.req_ready); end
                tick();
            end
            bus.tmr_done = 1'b1;
            tick();
            bus.tmr_done = 1'b0;
            checks++; if (bus.req_done !== exp_oh) begin errs++; $display("FAIL fair_done%0d got=%b exp=%b", s, bus.req_done, exp_oh); end
            else dones++;
        end
        bus.req_valid = 4'b0000;
        tick();
        checks++; if (dones != 6 || owner_valid !== 1'b0) begin errs++; $display("FAIL fair_count dones=%0d ov=%b exp 6/0", dones, owner_valid); end
    endtask

    task automatic test_busy();
        apply_reset();
        bus.req_mode       = 8'b0001_0000;
        bus.tmr_fire_ready = 1'b0;
        bus.req_valid      = 4'b0100;
        #1;
        checks++; if (bus.req_ready !== 4'b0100) begin errs++; $display("FAIL busy_grant got=%b exp=0100", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0011;
        for (int c = 1; c <= 10; c++) begin
            #1;
            checks++; if (bus.tmr_fire_valid !== 1'b1 || bus.tmr_mode !== 2'b01 || bus.req_ready !== 4'b0000) begin
                errs++; $display("FAIL busy_hold%0d fv=%b mode=%b ready=%b exp 1/01/0000", c, bus.tmr_fire_valid, bus.tmr_mode, bus.req_ready);
            end
            tick();
        end
        bus.tmr_fire_ready = 1'b1;
        tick();
        checks++; if (bus.tmr_fire_valid !== 1'b0 || owner_valid !== 1'b1 || bus.req_ready !== 4'b0000) begin
            errs++; $display("FAIL busy_accept fv=%b ov=%b ready=%b exp 0/1/0000", bus.tmr_fire_valid, owner_valid, bus.req_ready);
        end
        bus.tmr_done = 1'b1;
        tick();
        bus.tmr_done = 1'b0;
        checks++; if (bus.req_done !== 4'b0100) begin errs++; $display("FAIL busy_done got=%b exp=0100", bus.req_done); end
        // rr pointer is now 3: the search wraps to requester 0 before 1.
        checks++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL busy_wrap got=%b exp=0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
    endtask

    task automatic test_lost_done();
        int bad;
        apply_reset();
        bus.req_valid = 4'b0010;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        bad = 0;
        for (int k = 1; k < 300; k++) begin
            if (timeout_err !== 1'b0 || bus.req_done !== 4'b0000 || owner_valid !== 1'b1) bad++;
            tick();
        end
        checks++; if (bad != 0) begin errs++; $display("FAIL lost_early bad_cycles got=%0d exp=0", bad); end
        tick();
        checks++; if (timeout_err !== 1'b1 || bus.req_done !== 4'b0010 || owner_valid !== 1'b0) begin
            errs++; $display("FAIL lost_trip err=%b done=%b ov=%b exp 1/0010/0", timeout_err, bus.req_done, owner_valid);
        end
        tick();
        checks++; if (timeout_err !== 1'b1 || bus.req_done !== 4'b0000) begin errs++; $display("FAIL lost_sticky err=%b done=%b exp 1/0000", timeout_err, bus.req_done); end
        bus.req_mode  = 8'b1100_0000;
        bus.req_valid = 4'b1000;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errs++; $display("FAIL lost_next_grant got=%b exp=1000", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (bus.tmr_fire_valid !== 1'b1 || bus.tmr_mode !== 2'b11 || owner !== 2'd3) begin
            errs++; $display("FAIL lost_next_fire fv=%b mode=%b owner=%0d exp 1/11/3", bus.tmr_fire_valid, bus.tmr_mode, owner);
        end
        tick();
        bus.tmr_done = 1'b1;
        tick();
        bus.tmr_done = 1'b0;
        checks++; if (bus.req_done !== 4'b1000 || timeout_err !== 1'b1) begin errs++; $display("FAIL lost_next_done done=%b err=%b exp 1000/1", bus.req_done, timeout_err); end
    endtask

    task automatic test_done_at_trip();
        apply_reset();
        bus.req_valid = 4'b0001;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        for (int k = 1; k < 300; k++) tick();
        checks++; if (owner_valid !== 1'b1 || timeout_err !== 1'b0) begin errs++; $display("FAIL trip_edge_pre ov=%b err=%b exp 1/0", owner_valid, timeout_err); end
        bus.tmr_done = 1'b1;
        tick();
        bus.tmr_done = 1'b0;
        checks++; if (timeout_err !== 1'b0 || bus.req_done !== 4'b0001 || owner_valid !== 1'b0) begin
            errs++; $display("FAIL trip_edge_done err=%b done=%b ov=%b exp 0/0001/0", timeout_err, bus.req_done, owner_valid);
        end
    endtask

    task automatic test_stale_done();
        apply_reset();
        bus.tmr_done = 1'b1;
        tick();
        bus.tmr_done = 1'b0;
        checks++; if (bus.req_done !== 4'b0000 || owner_valid !== 1'b0) begin errs++; $display("FAIL stale_idle done=%b ov=%b exp 0000/0", bus.req_done, owner_valid); end
        bus.tmr_fire_ready = 1'b0;
        bus.req_valid      = 4'b0001;
        tick();
        bus.req_valid = 4'b0000;
        bus.tmr_done  = 1'b1;
        tick();
        bus.tmr_done = 1'b0;
        checks++; if (bus.req_done !== 4'b0000 || bus.tmr_fire_valid !== 1'b1 || owner_valid !== 1'b1) begin
            errs++; $display("FAIL stale_fire done=%b fv=%b ov=%b exp 0000/1/1", bus.req_done, bus.tmr_fire_valid, owner_valid);
        end
        bus.tmr_fire_ready = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (bus.req_done !== 4'b0000 || owner_valid !== 1'b1 || bus.tmr_fire_valid !== 1'b0) begin
            errs++; $display("FAIL stale_run done=%b ov=%b fv=%b exp 0000/1/0", bus.req_done, owner_valid, bus.tmr_fire_valid);
        end
        bus.tmr_done = 1'b1;
        tick();
        bus.tmr_done = 1'b0;
        checks++; if (bus.req_done !== 4'b0001) begin errs++; $display("FAIL stale_final got=%b exp=0001", bus.req_done); end
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        bus.req_valid = 4'b0100;
        tick();
        bus.req_valid = 4'b0000;
        tick();
        for (int k = 1; k < 20; k++) tick();
        bus.req_valid = 4'b1111;
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (owner_valid !== 1'b0 || bus.tmr_fire_valid !== 1'b0 || bus.req_done !== 4'b0000 || timeout_err !== 1'b0) begin
            errs++; $display("FAIL rst_mid ov=%b fv=%b done=%b err=%b exp 0/0/0000/0", owner_valid, bus.tmr_fire_valid, bus.req_done, timeout_err);
        end
        checks++; if (bus.req_ready !== 4'b0000) begin errs++; $display("FAIL rst_mid_ready got=%b exp=0000", bus.req_ready); end
        tick();
        rst_n = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errs++; $display("FAIL rst_rr_restart got=%b exp=0001", bus.req_ready); end
        tick();
        bus.req_valid = 4'b0000;
        checks++; if (owner !== 2'd0 || bus.tmr_fire_valid !== 1'b1) begin errs++; $display("FAIL rst_regrant owner=%0d fv=%b exp 0/1", owner, bus.tmr_fire_valid); end
    endtask

    initial begin
        clk                = 1'b0;
        rst_n              = 1'b0;
        errs               = 0;
        checks             = 0;
        bus.req_valid      = 4'b0000;
        bus.req_mode       = 8'h00;
        bus.tmr_fire_ready = 1'b1;
        bus.tmr_done       = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_busy();
        test_lost_done();
        test_done_at_trip();
        test_stale_done();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
